// File: rtl/cpu_ctrl_pkg.sv
// Control-word layout and opcode decode shared by the ID/EX stage and later pipeline stages.
// decode_op is pure combinational logic, so any stage can re-decode an opcode it carries.
package cpu_ctrl_pkg;

  localparam int CTRL_W = 18;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_b;
    logic [2:0] imm_op;
    logic       alu_src;
    logic       branch;
    logic       unsig;
    logic       jump;
    logic       direct;
    logic       reg_zero;
    logic       mem_read;
    logic       bh;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
  } ctrl_t;

  // Enum labels carry a prefix because MEM_WAIT is also the stage's wait-length parameter.
  typedef enum logic {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_t;

  function automatic ctrl_t decode_op(input logic [4:0] op);
    ctrl_t c;
    logic  addi;
    logic  rtype;
    addi         = (op[3:0] == 4'b1111);
    rtype        = addi & op[4];
    c.alu_src    = ~rtype;
    c.branch     = op[4] & ~op[3];
    c.jump       = (op == 5'd0) | (~op[4] & op[3] & ~op[2]);
    c.direct     = (op[4:2] == 3'b000);
    c.reg_zero   = ~op[1] & op[0];
    c.mem_read   = (op[4:2] == 3'b001);
    c.mem_to_reg = c.mem_read;
    c.bh         = op[1];
    c.unsig      = op[0];
    c.reg_write  = ~(op[4] & (~op[3] | ~op[2]));
    c.mem_write  = (op[4:2] == 3'b110);
    c.alu_op     = {c.branch | rtype, c.mem_read | rtype | addi};
    c.alu_b      = {op[3], op[1]};
    c.imm_op     = {c.direct & op[0], c.jump | c.branch, c.direct};
    return c;
  endfunction

endpackage

// File: rtl/id_ex_control_stage.sv
// Purpose: decode ID opcode into the ID/EX control register, inserting load-use and memory-wait bubbles.
// Latency: one cycle from accept (in_valid & in_ready) to ex_valid/ex_ctrl/ex_rd.
// Backpressure: in_ready drops on a load-use hazard or for MEM_WAIT cycles after a load/store; flush forces it high.
module id_ex_control_stage
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_AW   = 3,
  parameter int MEM_WAIT = 2,
  parameter int STALL_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         in_opcode,
  input  logic [REG_AW-1:0]  in_rs,
  input  logic [REG_AW-1:0]  in_rt,
  input  logic [REG_AW-1:0]  in_rd,
  input  logic               flush,
  output logic               ex_valid,
  output logic [CTRL_W-1:0]  ex_ctrl,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               mem_busy,
  output logic [STALL_W-1:0] stall_count
);

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  ctrl_t      ex_c;
  ctrl_t      dec;
  logic       hazard;
  logic       accept;
  logic       mem_op;

  assign ex_ctrl  = ex_c;
  assign mem_busy = (state == S_MEM_WAIT);

  // Both sources are compared regardless of opcode; r0 is hardwired so it never hazards.
  always_comb begin
    dec    = decode_op(in_opcode);
    mem_op = dec.mem_read | dec.mem_write;
    hazard = ex_valid & ex_c.mem_read & (ex_rd != '0) &
             ((ex_rd == in_rs) | (ex_rd == in_rt));
    if (rst || flush) begin
      in_ready = 1'b1;
    end else if (state == S_MEM_WAIT) begin
      in_ready = 1'b0;
    end else begin
      in_ready = ~hazard;
    end
    accept = in_valid & in_ready;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = S_RUN;
      cnt_nxt   = 4'd0;
    end else if (accept) begin
      if (mem_op && (MEM_WAIT > 0)) begin
        state_nxt = S_MEM_WAIT;
        cnt_nxt   = WAIT_INIT;
      end
    end else if (state == S_MEM_WAIT) begin
      cnt_nxt = cnt - 4'd1;
      if (cnt == 4'd1) begin
        state_nxt = S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      cnt         <= 4'd0;
      ex_valid    <= 1'b0;
      ex_c        <= '0;
      ex_rd       <= '0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (flush) begin
        ex_valid <= 1'b0;
        ex_c     <= '0;
      end else if (accept) begin
        ex_valid <= 1'b1;
        ex_c     <= dec;
        ex_rd    <= in_rd;
      end else begin
        ex_valid <= 1'b0;
        ex_c     <= '0;
      end
      if (in_valid && !in_ready && !flush && !(&stall_count)) begin
        stall_count <= stall_count + STALL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_control_stage.sv
// Drives three stage instances (MEM_WAIT 0/2/3, one with a 4-bit stall counter) with shared stimulus
// and compares each against an abstract reference model of the pipeline register.
module tb_id_ex_control_stage;

  logic       clk = 1'b0;
  logic       rst, in_valid, flush;
  logic [4:0] in_opcode;
  logic [2:0] in_rs, in_rt, in_rd;

  logic        rdy [3];
  logic        exv [3];
  logic        busy[3];
  logic [17:0] ctl [3];
  logic [2:0]  erd [3];
  logic [15:0] sc0, sc1;
  logic [3:0]  sc2;

  always #5 clk = ~clk;

  id_ex_control_stage #(.REG_AW(3), .MEM_WAIT(0), .STALL_W(16)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_opcode(in_opcode),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .flush(flush), .ex_valid(exv[0]),
    .ex_ctrl(ctl[0]), .ex_rd(erd[0]), .mem_busy(busy[0]), .stall_count(sc0));
  id_ex_control_stage #(.REG_AW(3), .MEM_WAIT(2), .STALL_W(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_opcode(in_opcode),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .flush(flush), .ex_valid(exv[1]),
    .ex_ctrl(ctl[1]), .ex_rd(erd[1]), .mem_busy(busy[1]), .stall_count(sc1));
  id_ex_control_stage #(.REG_AW(3), .MEM_WAIT(3), .STALL_W(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_opcode(in_opcode),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .flush(flush), .ex_valid(exv[2]),
    .ex_ctrl(ctl[2]), .ex_rd(erd[2]), .mem_busy(busy[2]), .stall_count(sc2));

  localparam logic [17:0] R_CTRL  = 18'b11_11_000_0_0_1_0_0_0_0_1_0_1_0;
  localparam logic [17:0] ST_CTRL = 18'b00_10_000_1_0_0_0_0_0_0_0_0_0_1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: EX contents, remaining wait cycles, stall tally.
  int          mw  [3] = '{0, 2, 3};
  int          smax[3] = '{65535, 65535, 15};
  bit          m_v [3];
  logic [17:0] m_c [3];
  logic [2:0]  m_rd[3];
  int          m_w [3];
  int          m_s [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sc(input int i);
    case (i)
      0:       return int'(sc0);
      1:       return int'(sc1);
      default: return int'(sc2);
    endcase
  endfunction

  function automatic logic [17:0] ref_ctrl(input logic [4:0] op);
    bit addi  = (op[3:0] == 4'hF);
    bit rtype = addi && op[4];
    bit br    = op[4] && !op[3];
    bit jmp   = (op == 5'd0) || (!op[4] && op[3] && !op[2]);
    bit dir   = (op[4:2] == 3'd0);
    bit mr    = (op[4:2] == 3'd1);
    bit mwr   = (op[4:2] == 3'd6);
    bit rw    = !(op[4] && (!op[3] || !op[2]));
    return {br | rtype, mr | rtype | addi, op[3], op[1], dir & op[0], jmp | br, dir,
            !rtype, br, op[0], jmp, dir, !op[1] & op[0], mr, op[1], mr, rw, mwr};
  endfunction

  task automatic step(input bit r, input bit v, input bit f, input logic [4:0] op,
                      input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd);
    @(negedge clk);
    rst = r; in_valid = v; flush = f; in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd;
    #1;
    for (int i = 0; i < 3; i++) begin
      bit          hz, rdy_e, memop;
      logic [17:0] dc;
      dc    = ref_ctrl(op);
      memop = (op[4:2] == 3'd1) || (op[4:2] == 3'd6);
      hz    = m_v[i] && m_c[i][4] && (m_rd[i] != 3'd0) && (m_rd[i] == rs || m_rd[i] == rt);
      rdy_e = r || f || (m_w[i] == 0 && !hz);
      check($sformatf("u%0d_ex_valid", i), 32'(exv[i]), 32'(m_v[i]));
      check($sformatf("u%0d_ex_ctrl", i), 32'(ctl[i]), 32'(m_c[i]));
      check($sformatf("u%0d_ex_rd", i), 32'(erd[i]), 32'(m_rd[i]));
      check($sformatf("u%0d_stall_count", i), sc(i), m_s[i]);
      check($sformatf("u%0d_in_ready", i), 32'(rdy[i]), 32'(rdy_e));
      if (!r) check($sformatf("u%0d_mem_busy", i), 32'(busy[i]), 32'(m_w[i] > 0));
      if (r) begin
        m_v[i] = 0; m_c[i] = '0; m_rd[i] = '0; m_w[i] = 0; m_s[i] = 0;
      end else begin
        if (v && !rdy_e && !f && m_s[i] < smax[i]) m_s[i]++;
        if (f) begin
          m_v[i] = 0; m_c[i] = '0; m_w[i] = 0;
        end else if (v && rdy_e) begin
          m_v[i] = 1; m_c[i] = dc; m_rd[i] = rd;
          if (memop && mw[i] > 0) m_w[i] = mw[i];
        end else begin
          m_v[i] = 0; m_c[i] = '0;
          if (m_w[i] > 0) m_w[i]--;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 5'd0, 3'd0, 3'd0, 3'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in_opcode = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    for (int i = 0; i < 3; i++) begin
      m_v[i] = 0; m_c[i] = '0; m_rd[i] = '0; m_w[i] = 0; m_s[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    step(1, 1, 0, 5'b00100, 3'd1, 3'd1, 3'd1);
    step(1, 0, 0, 5'd0, 3'd0, 3'd0, 3'd0);
    check("rst_busy", 32'(busy[1]), 32'd0);
    check("rst_ready", 32'(rdy[2]), 32'd1);

    // R-type issue
    step(0, 1, 0, 5'b11111, 3'd0, 3'd0, 3'd2);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rtype_ctrl_u%0d", i), 32'(ctl[i]), 32'(R_CTRL));
      check($sformatf("rtype_rd_u%0d", i), 32'(erd[i]), 32'd2);
    end

    // Load-use on r3: one bubble on the MEM_WAIT=0 instance
    step(0, 1, 0, 5'b00100, 3'd0, 3'd0, 3'd3);
    step(0, 1, 0, 5'b11111, 3'd3, 3'd0, 3'd1);
    check("lu_bubble", 32'(exv[0]), 32'd0);
    step(0, 1, 0, 5'b11111, 3'd3, 3'd0, 3'd1);
    check("lu_stall_cnt", 32'(sc0), 32'd1);
    check("lu_issue", 32'(ctl[0]), 32'(R_CTRL));
    idle(4);

    // Load to r0 never hazards
    step(0, 1, 0, 5'b00100, 3'd0, 3'd0, 3'd0);
    step(0, 1, 0, 5'b11111, 3'd0, 3'd0, 3'd1);
    check("r0_no_stall", 32'(sc0), 32'd1);
    check("r0_issue", 32'(ctl[0]), 32'(R_CTRL));
    idle(4);

    // Store, then flush on the first wait cycle
    step(0, 1, 0, 5'b11000, 3'd0, 3'd0, 3'd5);
    check("store_ctrl", 32'(ctl[1]), 32'(ST_CTRL));
    check("store_busy", 32'(busy[1]), 32'd1);
    step(0, 1, 1, 5'b11111, 3'd0, 3'd0, 3'd4);
    check("flush_busy", 32'(busy[1]), 32'd0);
    check("flush_bubble", 32'(exv[1]), 32'd0);

    // Store without flush: wait window followed by R-types
    step(0, 1, 0, 5'b11000, 3'd0, 3'd0, 3'd5);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 5'b11111, 3'd1, 3'd2, 3'd6);

    // Continuous stores saturate the 4-bit counter
    for (int k = 0; k < 40; k++) step(0, 1, 0, 5'b11000, 3'd0, 3'd0, 3'd1);
    check("sat_count", 32'(sc2), 32'd15);

    for (int k = 0; k < 1500; k++) begin
      logic [4:0] op;
      case ($urandom_range(0, 4))
        0:       op = {3'b001, 2'($urandom)};
        1:       op = {3'b110, 2'($urandom)};
        default: op = 5'($urandom);
      endcase
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           op, 3'($urandom), 3'($urandom), 3'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
